// File: rtl/pin_entry_unit.sv
// Keypad PIN collector: buffers four hex digits and submits them as code with a timed code_ack strobe.
// Optional inter-key timeout is built only when PIN_ENTRY_TIMEOUT_EN is defined.
module pin_entry_unit #(
   parameter int ACK_LEN        = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vehicle_arrival,
   input  logic        key_valid,
   input  logic [3:0]  key_value,
   output logic [15:0] code,
   output logic        code_ack,
   output logic [2:0]  digit_count,
   output logic        entry_error
);

   typedef enum logic [1:0] {IDLE, ENTRY, ACK} state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_BACK  = 4'hB;
   localparam logic [3:0] KEY_ENTER = 4'hE;

   state_t      state, next_state;
   logic [15:0] buffer, nxt_buffer;
   logic [2:0]  nxt_count;
   logic [15:0] nxt_code;
   logic        nxt_ack;
   logic        nxt_error;
   logic [7:0]  ack_cnt, nxt_ack_cnt;
   logic        enter_ok;
   logic        timeout_hit;

   assign enter_ok = (state == ENTRY) && vehicle_arrival && key_valid &&
                     (key_value == KEY_ENTER) && (digit_count == 3'd4);

`ifdef PIN_ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt, nxt_tmo_cnt;
   logic          tmo_armed;

   // Counts only idle cycles of a partial entry; any key restarts the window.
   assign tmo_armed   = (state == ENTRY) && vehicle_arrival && !key_valid && (digit_count != 3'd0);
   assign timeout_hit = tmo_armed && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      nxt_tmo_cnt = '0;
      if (tmo_armed && !timeout_hit)
         nxt_tmo_cnt = tmo_cnt + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         tmo_cnt <= '0;
      else
         tmo_cnt <= nxt_tmo_cnt;
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         buffer      <= '0;
         digit_count <= '0;
         code        <= '0;
         code_ack    <= 1'b0;
         entry_error <= 1'b0;
         ack_cnt     <= '0;
      end else begin
         state       <= next_state;
         buffer      <= nxt_buffer;
         digit_count <= nxt_count;
         code        <= nxt_code;
         code_ack    <= nxt_ack;
         entry_error <= nxt_error;
         ack_cnt     <= nxt_ack_cnt;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (vehicle_arrival) next_state = ENTRY;
         ENTRY: begin
            if (!vehicle_arrival) next_state = IDLE;
            else if (enter_ok)    next_state = ACK;
         end
         ACK: begin
            if (!vehicle_arrival)      next_state = IDLE;
            else if (ack_cnt == 8'd0)  next_state = ENTRY;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      nxt_buffer  = buffer;
      nxt_count   = digit_count;
      nxt_code    = code;
      nxt_ack     = code_ack;
      nxt_error   = 1'b0;
      nxt_ack_cnt = ack_cnt;
      case (state)
         ENTRY: begin
            if (!vehicle_arrival) begin
               nxt_buffer = '0;
               nxt_count  = '0;
            end else if (key_valid) begin
               if (key_value <= 4'h9) begin
                  if (digit_count < 3'd4) begin
                     nxt_buffer = {buffer[11:0], key_value};
                     nxt_count  = digit_count + 3'd1;
                  end else begin
                     nxt_error = 1'b1;
                  end
               end else if (key_value == KEY_CLEAR) begin
                  nxt_buffer = '0;
                  nxt_count  = '0;
               end else if (key_value == KEY_BACK) begin
                  if (digit_count != 3'd0) begin
                     nxt_buffer = buffer >> 4;
                     nxt_count  = digit_count - 3'd1;
                  end
               end else if (key_value == KEY_ENTER) begin
                  if (enter_ok) begin
                     nxt_code    = buffer;
                     nxt_ack     = 1'b1;
                     nxt_ack_cnt = 8'(ACK_LEN - 1);
                  end else begin
                     nxt_error = 1'b1;
                  end
               end
            end else if (timeout_hit) begin
               nxt_buffer = '0;
               nxt_count  = '0;
               nxt_error  = 1'b1;
            end
         end
         ACK: begin
            // Keys are ignored here; abort and expiry both flush everything.
            if (!vehicle_arrival || ack_cnt == 8'd0) begin
               nxt_buffer  = '0;
               nxt_count   = '0;
               nxt_code    = '0;
               nxt_ack     = 1'b0;
               nxt_ack_cnt = '0;
            end else begin
               nxt_ack_cnt = ack_cnt - 8'd1;
            end
         end
         default: begin
            nxt_buffer  = '0;
            nxt_count   = '0;
            nxt_code    = '0;
            nxt_ack     = 1'b0;
            nxt_ack_cnt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pin_entry_unit.sv
// Directed self-checking bench for pin_entry_unit (ACK_LEN = 4, TIMEOUT_CYCLES = 8).
module tb_pin_entry_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        vehicle_arrival;
   logic        key_valid;
   logic [3:0]  key_value;
   logic [15:0] code;
   logic        code_ack;
   logic [2:0]  digit_count;
   logic        entry_error;

   int checks   = 0;
   int failures = 0;

   pin_entry_unit #(.ACK_LEN(4), .TIMEOUT_CYCLES(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .vehicle_arrival (vehicle_arrival),
      .key_valid       (key_valid),
      .key_value       (key_value),
      .code            (code),
      .code_ack        (code_ack),
      .digit_count     (digit_count),
      .entry_error     (entry_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_value = k;
      tick();
      key_valid = 1'b0;
      key_value = 4'h0;
   endtask

   // Called right after the enter edge: ack already seen once, ACK_LEN-1 more cycles follow.
   task automatic finish_ack(input string tag);
      repeat (3) tick();
      check({tag, "_ack_last"}, 32'(code_ack), 32'd1);
      tick();
      check({tag, "_ack_off"}, 32'(code_ack), 32'd0);
      check({tag, "_code_off"}, 32'(code), 32'd0);
      check({tag, "_cnt_off"}, 32'(digit_count), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      vehicle_arrival = 1'b0;
      key_valid = 1'b0;
      key_value = 4'h0;
      repeat (2) tick();
      check("rst_code", 32'(code), 32'd0);
      check("rst_ack", 32'(code_ack), 32'd0);
      check("rst_cnt", 32'(digit_count), 32'd0);
      check("rst_err", 32'(entry_error), 32'd0);

      // Key in IDLE is dropped; entry starts one edge after arrival is seen.
      rst = 1'b1;
      vehicle_arrival = 1'b1;
      press(4'h7);
      check("idle_key_drop", 32'(digit_count), 32'd0);

      // Basic submission 5990, key during ACK ignored.
      press(4'h5); press(4'h9); press(4'h9); press(4'h0);
      check("t1_cnt4", 32'(digit_count), 32'd4);
      press(4'hE);
      check("t1_ack", 32'(code_ack), 32'd1);
      check("t1_code", 32'(code), 32'h5990);
      press(4'h3);
      check("t1_ack2", 32'(code_ack), 32'd1);
      check("t1_code2", 32'(code), 32'h5990);
      check("t1_key_in_ack_err", 32'(entry_error), 32'd0);
      repeat (2) tick();
      check("t1_ack4", 32'(code_ack), 32'd1);
      tick();
      check("t1_ack_off", 32'(code_ack), 32'd0);
      check("t1_code_off", 32'(code), 32'd0);
      check("t1_cnt_off", 32'(digit_count), 32'd0);

      // Short enter, overflow digit, then 1234.
      press(4'h1); press(4'h2); press(4'hE);
      check("t2_short_err", 32'(entry_error), 32'd1);
      check("t2_short_cnt", 32'(digit_count), 32'd2);
      check("t2_short_ack", 32'(code_ack), 32'd0);
      tick();
      check("t2_err_pulse", 32'(entry_error), 32'd0);
      press(4'h3); press(4'h4);
      check("t2_no_err", 32'(entry_error), 32'd0);
      press(4'h5);
      check("t2_over_err", 32'(entry_error), 32'd1);
      check("t2_over_cnt", 32'(digit_count), 32'd4);
      press(4'hE);
      check("t2_ack", 32'(code_ack), 32'd1);
      check("t2_code", 32'(code), 32'h1234);
      finish_ack("t2");

      // Backspace then 1299; clear then short enter.
      press(4'h1); press(4'h2); press(4'h3); press(4'hB);
      check("t3_bs_cnt", 32'(digit_count), 32'd2);
      press(4'h9); press(4'h9); press(4'hE);
      check("t3_code", 32'(code), 32'h1299);
      finish_ack("t3");
      press(4'hB);
      check("t3_bs_empty_err", 32'(entry_error), 32'd0);
      press(4'h7); press(4'hA);
      check("t3_clr_cnt", 32'(digit_count), 32'd0);
      press(4'hE);
      check("t3_clr_err", 32'(entry_error), 32'd1);
      check("t3_clr_cnt2", 32'(digit_count), 32'd0);

      // Inter-key timeout window of 8 idle cycles.
      press(4'h4);
      check("t4_cnt1", 32'(digit_count), 32'd1);
      repeat (7) tick();
      check("t4_cnt_pre", 32'(digit_count), 32'd1);
      check("t4_err_pre", 32'(entry_error), 32'd0);
      tick();
`ifdef PIN_ENTRY_TIMEOUT_EN
      check("t4_tmo_cnt", 32'(digit_count), 32'd0);
      check("t4_tmo_err", 32'(entry_error), 32'd1);
`else
      check("t4_tmo_cnt", 32'(digit_count), 32'd1);
      check("t4_tmo_err", 32'(entry_error), 32'd0);
`endif
      tick();
      check("t4_err_end", 32'(entry_error), 32'd0);
      press(4'hA);

      // Abort on the 2nd ack cycle.
      press(4'h1); press(4'h1); press(4'h1); press(4'h1); press(4'hE);
      tick();
      check("t5_ack2", 32'(code_ack), 32'd1);
      vehicle_arrival = 1'b0;
      tick();
      check("t5_abort_ack", 32'(code_ack), 32'd0);
      check("t5_abort_code", 32'(code), 32'd0);
      check("t5_abort_cnt", 32'(digit_count), 32'd0);
      press(4'h5);
      check("t5_idle_key", 32'(digit_count), 32'd0);
      vehicle_arrival = 1'b1;
      tick();

      // Reset during entry and during ACK.
      press(4'h1); press(4'h2); press(4'h3);
      check("t6_cnt3", 32'(digit_count), 32'd3);
      rst = 1'b0;
      tick();
      check("t6_rst_cnt", 32'(digit_count), 32'd0);
      rst = 1'b1;
      tick();
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hE);
      tick();
      rst = 1'b0;
      tick();
      check("t6_rst_ack", 32'(code_ack), 32'd0);
      check("t6_rst_code", 32'(code), 32'd0);
      check("t6_rst_cnt2", 32'(digit_count), 32'd0);
      rst = 1'b1;
      tick();
      press(4'h6); press(4'h7); press(4'h8); press(4'h9); press(4'hE);
      check("t6_code", 32'(code), 32'h6789);
      check("t6_ack", 32'(code_ack), 32'd1);
      finish_ack("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pin_entry_unit.md
# pin_entry_unit

- Keypad front end for the parking controller.
- Collects four hex digits while a vehicle is present and assembles them into the 16-bit `code` word.
- Presents `code` to the controller with a timed `code_ack` strobe, so it is the transmitter side of the `code`/`code_ack` interface.
- Supports clear, backspace, enter-validation and an optional inter-key timeout.

## Interface

Parameters:
- `ACK_LEN`, 4: cycles `code_ack` is held high per submission; legal range 1..255.
- `TIMEOUT_CYCLES`, 1000: idle cycles before a partial entry is discarded; legal minimum 2.

Ports:
- `clk` — input, 1 bit: rising-edge clock.
- `rst` — input, 1 bit: reset; synchronous, active-low.
- `vehicle_arrival` — input, 1 bit: high while a vehicle waits at the gate; enables entry.
- `key_valid` — input, 1 bit: one-cycle strobe qualifying `key_value`.
- `key_value` — input, 4 bits: 0x0–0x9 digit, 0xA clear, 0xB backspace, 0xE enter; all other values are ignored.
- `code` — output, 16 bits: submitted PIN; non-zero only while `code_ack` is high.
- `code_ack` — output, 1 bit: submission strobe to the controller.
- `digit_count` — output, 3 bits: digits currently buffered (0..4), for display.
- `entry_error` — output, 1 bit: one-cycle pulse on a rejected key or a timeout.

## Operation

States:
- IDLE: buffer = 0, count = 0. Go to ENTRY when `vehicle_arrival` = 1.
- ENTRY: accept keys.
  - digit with count < 4: buffer ← {buffer[11:0], digit}; count + 1. The first key lands in the MSB nibble, so keys 5,9,9,0 give 16'h5990.
  - digit with count = 4: ignored; `entry_error` pulse.
  - clear: buffer = 0, count = 0.
  - backspace: buffer ← buffer >> 4; count − 1. Ignored with no error when count = 0.
  - enter with count = 4: go to ACK, latching the buffer into `code`.
  - enter with count < 4: ignored; `entry_error` pulse; buffer kept.
- ACK: `code_ack` = 1 and `code` = latched value for `ACK_LEN` cycles.
  - All keys are ignored, with no error.
  - On expiry: buffer = 0, count = 0, `code` = 0, `code_ack` = 0. Next state is ENTRY if `vehicle_arrival` = 1, else IDLE.
- Abort: `vehicle_arrival` = 0 in ENTRY or ACK sends the block to IDLE on the next edge.
  - Buffer, count, `code` and `code_ack` are all cleared, including mid-ACK.
  - A key arriving in the same cycle is discarded.
- Widths: the ACK counter is 8 bits; the timeout counter is $clog2(`TIMEOUT_CYCLES`) bits. Neither counter wraps; both saturate or reload explicitly.

## Timing

- All outputs are registered.
- Reset values: `code` = 0, `code_ack` = 0, `digit_count` = 0, `entry_error` = 0, state = IDLE. Timeout and ACK counters are 0.
- Reset mid-operation clears everything on that edge; outputs are reset-valued the cycle after `rst` is sampled low.
- IDLE → ENTRY: keys are accepted from the first edge at which ENTRY is the current state. A key that arrives while still in IDLE is dropped.
- Key sampled at edge N: `digit_count` and the buffer update at N+1; `entry_error` is high for the single cycle N+1.
- Enter sampled at edge N: `code` and `code_ack` are high from N+1 through N+`ACK_LEN`, and both are low at N+`ACK_LEN`+1.
- Back-to-back keys on consecutive cycles are each processed.

## Configuration

- Macro: `PIN_ENTRY_TIMEOUT_EN`.
- Defined: in ENTRY with count > 0, the timeout counter increments on every cycle without `key_valid`. Any sampled key reloads it to 0.
- On reaching `TIMEOUT_CYCLES`−1, the buffer and count clear on the next edge and `entry_error` pulses.
- Undefined: no timeout counter is built; a partial entry persists until clear, abort or reset.

## Test plan

- Reset, `vehicle_arrival` = 1, keys 5,9,9,0,E → `code` = 16'h5990 with `code_ack` = 1 for exactly 4 cycles; then both 0 and `digit_count` = 0.
- Keys 1,2,E → `entry_error` pulse, `digit_count` stays 2, no `code_ack`. Then 3,4,5 → `entry_error` on the 5; then E → `code` = 16'h1234.
- Keys 1,2,3,B,9,9,E → `code` = 16'h1299. Keys 7,A,E → `entry_error`, `digit_count` = 0.
- With `PIN_ENTRY_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: key 4, then 8 idle cycles → `digit_count` returns to 0 with one `entry_error` pulse. Without the macro: `digit_count` stays 1.
- `vehicle_arrival` drops on the 2nd `code_ack` cycle → `code_ack` = 0 and `code` = 0 next cycle; state IDLE; later keys are ignored.
- `rst` = 0 in ENTRY with 3 digits buffered, and again mid-ACK → all outputs 0 one cycle later; the next full entry works normally.
